// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer
// Sequences the BRAM line-buffer delay lines of the streaming pixel pipeline.
// It measures the active line width, drives the delay-line ce/rst/h_size and
// tracks pixel coordinates. It also flags when a full WIN x WIN context window
// around the delayed pixel lies inside the frame.
// All outputs are registered, one cycle after the in_de/in_vsync sample they describe.
// Optional build macro FRAME_STATS_EN adds v_size (lines in the previous frame)
// and frame_cnt (vsync rises seen, wrapping) outputs.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | after reset, delay lines held off until the first vsync rise
// S_MEASURE | measuring a line width; a line of at least WIN+2 pixels locks
// S_RUN     | width locked, every line compared against dl_h_size
module line_buffer_sequencer #(
    parameter int H_W = 11,
    parameter int V_W = 11,
    parameter int WIN = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_de,
    input  logic           in_vsync,
    output logic           dl_ce,
    output logic           dl_rst,
    output logic [H_W-1:0] dl_h_size,
    output logic [H_W-1:0] x_pos,
    output logic [V_W-1:0] y_pos,
    output logic           ctx_valid,
    output logic           locked,
    output logic           err
`ifdef FRAME_STATS_EN
    ,
    output logic [V_W-1:0] v_size,
    output logic [15:0]    frame_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    localparam logic [H_W-1:0] X_MAX = {H_W{1'b1}};
    localparam logic [V_W-1:0] Y_MAX = {V_W{1'b1}};
    localparam logic [H_W-1:0] MIN_W = H_W'(WIN + 2);
    localparam logic [H_W-1:0] CTX_X = H_W'(WIN - 1);
    localparam logic [V_W-1:0] CTX_Y = V_W'(WIN - 1);

    state_t         state_q, state_d;
    logic           de_q, vs_q;
    logic           skip_q, skip_d;
    logic [H_W-1:0] x_q, x_d;
    logic [V_W-1:0] y_q, y_d;
    logic [H_W-1:0] hsize_q, hsize_d;
    logic           err_q, err_d;
    logic           ce_q, ce_d;
    logic           dlrst_q, dlrst_d;
    logic           locked_q, locked_d;
    logic           ctx_q, ctx_d;

    logic           vs_rise;
    logic           de_fall;
    logic [H_W-1:0] width;

    assign vs_rise = in_vsync & ~vs_q;
    assign de_fall = ~in_de & de_q;
    // x_q holds the column of the last pixel when de falls; saturate so an
    // overlong line cannot wrap into a small, plausible width.
    assign width   = (x_q == X_MAX) ? X_MAX : x_q + H_W'(1);

    // Next-state logic: vsync rise has priority over any line event.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hsize_d = hsize_q;
        err_d   = err_q;
        skip_d  = skip_q;

        if (vs_rise) begin
            state_d = S_MEASURE;
            x_d     = '0;
            y_d     = '0;
            err_d   = 1'b0;
            // vsync in the middle of a line: the remainder is not a real line
            skip_d  = in_de;
        end else if (state_q != S_IDLE) begin
            if (de_fall) begin
                x_d    = '0;
                skip_d = 1'b0;
                if (!skip_q) begin
                    if (y_q != Y_MAX) begin
                        y_d = y_q + V_W'(1);
                    end
                    case (state_q)
                        S_MEASURE: begin
                            if (width < MIN_W) begin
                                err_d = 1'b1;
                            end else begin
                                hsize_d = width;
                                state_d = S_RUN;
                            end
                        end
                        S_RUN: begin
                            if (width != hsize_q) begin
                                err_d   = 1'b1;
                                state_d = S_MEASURE;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (in_de) begin
                if (!de_q) begin
                    x_d = '0;
                end else if (x_q != X_MAX) begin
                    x_d = x_q + H_W'(1);
                end
                if (de_q && (x_q >= X_MAX - H_W'(1))) begin
                    err_d = 1'b1;
                end
            end
        end

        ce_d     = (state_d != S_IDLE) & in_de;
        // delay-line reset covers the first enabled cycle of the frame
        dlrst_d  = vs_rise ? 1'b1 : (ce_q ? 1'b0 : dlrst_q);
        locked_d = (state_d == S_RUN);
        ctx_d    = locked_d & ce_d & (x_d >= CTX_X) & (y_d >= CTX_Y);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            de_q     <= 1'b0;
            vs_q     <= 1'b0;
            skip_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hsize_q  <= '0;
            err_q    <= 1'b0;
            ce_q     <= 1'b0;
            dlrst_q  <= 1'b1;
            locked_q <= 1'b0;
            ctx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            de_q     <= in_de;
            vs_q     <= in_vsync;
            skip_q   <= skip_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsize_q  <= hsize_d;
            err_q    <= err_d;
            ce_q     <= ce_d;
            dlrst_q  <= dlrst_d;
            locked_q <= locked_d;
            ctx_q    <= ctx_d;
        end
    end

    assign dl_ce     = ce_q;
    assign dl_rst    = dlrst_q;
    assign dl_h_size = hsize_q;
    assign x_pos     = x_q;
    assign y_pos     = y_q;
    assign ctx_valid = ctx_q;
    assign locked    = locked_q;
    assign err       = err_q;

`ifdef FRAME_STATS_EN
    logic [V_W-1:0] v_size_q;
    logic [15:0]    frame_cnt_q;

    // Per-frame statistics captured at each vsync rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_size_q    <= '0;
            frame_cnt_q <= '0;
        end else if (vs_rise) begin
            v_size_q    <= y_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign v_size    = v_size_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Testbench for line_buffer_sequencer: directed test-plan scenarios followed by
// randomized frames. A line/frame-level reference model predicts each output
// cycle into a scoreboard queue that an independent monitor drains.
module tb_line_buffer_sequencer;

    localparam int H_W   = 11;
    localparam int V_W   = 11;
    localparam int WIN   = 3;
    localparam int H_MAX = (1 << H_W) - 1;
    localparam int V_MAX = (1 << V_W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_de = 1'b0;
    logic           in_vsync = 1'b0;
    logic           dl_ce, dl_rst, ctx_valid, locked, err;
    logic [H_W-1:0] dl_h_size, x_pos;
    logic [V_W-1:0] y_pos;
`ifdef FRAME_STATS_EN
    logic [V_W-1:0] v_size;
    logic [15:0]    frame_cnt;
`endif

    line_buffer_sequencer #(.H_W(H_W), .V_W(V_W), .WIN(WIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_de     (in_de),
        .in_vsync  (in_vsync),
        .dl_ce     (dl_ce),
        .dl_rst    (dl_rst),
        .dl_h_size (dl_h_size),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .ctx_valid (ctx_valid),
        .locked    (locked),
        .err       (err)
`ifdef FRAME_STATS_EN
        ,
        .v_size    (v_size),
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           ce;
        logic           dlrst;
        logic [H_W-1:0] hs;
        logic [H_W-1:0] x;
        logic [V_W-1:0] y;
        logic           ctx;
        logic           lk;
        logic           er;
`ifdef FRAME_STATS_EN
        logic [V_W-1:0] vs;
        logic [15:0]    fc;
`endif
    } obs_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode 0 = waiting for first vsync, 1 = measuring, 2 = locked
    int m_mode, m_prev_de, m_prev_vs, m_count, m_line, m_hsize;
    int m_err, m_discard, m_rstpend, m_frames, m_vsize;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit d, input bit v);
        obs_t e;
        bit   vr, df;
        int   w, x_out;
        if (r) begin
            m_mode = 0; m_prev_de = 0; m_prev_vs = 0; m_count = 0; m_line = 0;
            m_hsize = 0; m_err = 0; m_discard = 0; m_rstpend = 1;
            m_frames = 0; m_vsize = 0;
        end else begin
            vr = v && !m_prev_vs;
            df = !d && m_prev_de;
            m_prev_de = d;
            m_prev_vs = v;
            if (vr) begin
                m_vsize   = m_line;
                m_frames  = (m_frames + 1) % 65536;
                m_mode    = 1;
                m_count   = d ? 1 : 0;
                m_line    = 0;
                m_err     = 0;
                m_discard = d;
                m_rstpend = 1;
            end else if (m_mode != 0) begin
                if (df) begin
                    w = imin(m_count, H_MAX);
                    m_count = 0;
                    if (m_discard != 0) begin
                        m_discard = 0;
                    end else begin
                        m_line = imin(m_line + 1, V_MAX);
                        if (m_mode == 1) begin
                            if (w < WIN + 2) m_err = 1;
                            else begin
                                m_hsize = w;
                                m_mode  = 2;
                            end
                        end else if (w != m_hsize) begin
                            m_err  = 1;
                            m_mode = 1;
                        end
                    end
                end else if (d) begin
                    m_count++;
                    if (m_count - 1 >= H_MAX) m_err = 1;
                end
            end
        end
        x_out   = (d && !r && m_mode != 0) ? imin(m_count - 1, H_MAX) : 0;
        e.ce    = !r && (m_mode != 0) && d;
        e.dlrst = (m_rstpend != 0);
        if (e.ce) m_rstpend = 0;
        e.hs    = H_W'(m_hsize);
        e.x     = H_W'(x_out);
        e.y     = V_W'(m_line);
        e.lk    = (m_mode == 2);
        e.ctx   = e.lk && e.ce && (x_out >= WIN - 1) && (m_line >= WIN - 1);
        e.er    = (m_err != 0);
`ifdef FRAME_STATS_EN
        e.vs    = V_W'(m_vsize);
        e.fc    = 16'(m_frames);
`endif
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit d, input bit v);
        @(negedge clk);
        rst      = r;
        in_de    = d;
        in_vsync = v;
        model_step(r, d, v);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    task automatic vpulse(input int n);
        repeat (n) drive(0, 0, 1);
        drive(0, 0, 0);
    endtask

    task automatic line(input int n, input int gap);
        repeat (n) drive(0, 1, 0);
        idle(gap);
    endtask

    task automatic dcheck(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: every clock the DUT presents one output vector for the sample
    // taken at that edge; compare it against the oldest prediction.
    always begin
        obs_t a, e;
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a.ce = dl_ce; a.dlrst = dl_rst; a.hs = dl_h_size; a.x = x_pos;
            a.y = y_pos; a.ctx = ctx_valid; a.lk = locked; a.er = err;
`ifdef FRAME_STATS_EN
            a.vs = v_size; a.fc = frame_cnt;
`endif
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs @%0t: got ce=%b rst=%b hs=%0d x=%0d y=%0d ctx=%b lk=%b err=%b, expected ce=%b rst=%b hs=%0d x=%0d y=%0d ctx=%b lk=%b err=%b",
                          $time, a.ce, a.dlrst, a.hs, a.x, a.y, a.ctx, a.lk, a.er,
                          e.ce, e.dlrst, e.hs, e.x, e.y, e.ctx, e.lk, e.er);
        end
    end

    initial begin
        int nom, nl, r, w;
        // reset
        repeat (3) drive(1, 0, 0);
        settle();
        dcheck("reset_dl_rst", dl_rst, 1);
        dcheck("reset_dl_ce", dl_ce, 0);

        // frame 1: four 16-pixel lines
        idle(2);
        vpulse(2);
        idle(3);
        repeat (4) line(16, 4);
        settle();
        dcheck("f1_h_size", dl_h_size, 16);
        dcheck("f1_locked", locked, 1);
        dcheck("f1_y", y_pos, 4);

        // frame 2: second line one pixel short
        vpulse(1);
        idle(2);
        line(16, 4);
        line(15, 4);
        settle();
        dcheck("f2_err_after_short", err, 1);
        dcheck("f2_unlocked", locked, 0);
        line(16, 4);
        line(16, 4);
        settle();
        dcheck("f2_relock", locked, 1);
        dcheck("f2_err_sticky", err, 1);

        // frame 3: too-short first line, then 10-pixel lines
        vpulse(1);
        settle();
        dcheck("f3_err_cleared", err, 0);
        idle(2);
        line(4, 3);
        settle();
        dcheck("f3_short_err", err, 1);
        dcheck("f3_short_unlocked", locked, 0);
        line(10, 3);
        line(10, 3);
        settle();
        dcheck("f3_h_size", dl_h_size, 10);

        // vsync rise coinciding with de fall
        vpulse(1);
        idle(2);
        line(10, 3);
        line(10, 3);
        repeat (10) drive(0, 1, 0);
        drive(0, 0, 1);
        settle();
        dcheck("tie_y", y_pos, 0);
        dcheck("tie_dl_rst", dl_rst, 1);
        dcheck("tie_locked", locked, 0);
        drive(0, 0, 0);
        idle(2);
        line(12, 3);
        line(12, 3);

        // vsync mid-line: remainder of the line discarded
        repeat (5) drive(0, 1, 0);
        drive(0, 1, 1);
        repeat (4) drive(0, 1, 0);
        idle(3);
        line(11, 3);
        line(11, 3);

        // reset mid-line in RUN, lines without vsync stay disabled
        repeat (6) drive(0, 1, 0);
        drive(1, 1, 0);
        settle();
        dcheck("rst_mid_ce", dl_ce, 0);
        dcheck("rst_mid_locked", locked, 0);
        line(8, 3);
        line(8, 3);
        vpulse(2);
        idle(2);
        repeat (3) line(9, 2);

        // randomized frames
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 14) == 0) begin
                repeat ($urandom_range(1, 3)) drive(1, 0, 0);
            end
            vpulse($urandom_range(1, 3));
            idle($urandom_range(1, 4));
            nom = $urandom_range(5, 40);
            nl  = $urandom_range(3, 8);
            for (int l = 0; l < nl; l++) begin
                r = $urandom_range(0, 19);
                if (r < 2)      w = $urandom_range(1, 4);
                else if (r < 4) w = nom - 1;
                else if (r < 6) w = nom + 1;
                else            w = nom;
                line(w, $urandom_range(1, 5));
            end
        end

        idle(4);
        settle();
        dcheck("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
